// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Brief    : Shared widths, owner encoding and helpers for the data-memory
//            arbiter between the CPU load/store path and the EXT host port.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  localparam int c_addr_w   = 16;
  localparam int c_data_w   = 16;
  localparam int c_max_wait = 4;

  // Which requester a pending read response belongs to.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

  // Width of the starvation counter; never narrower than one bit.
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Request/response bundle for both requesters plus the memory side.
//            slave  = arbiter view, master = requesters + memory view.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/dmem_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : dmem_starve_ctr
// Brief    : Counts consecutive cycles EXT is denied while CPU is granted and
//            raises ext_priority once that count reaches MAX_WAIT.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_starve_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = c_max_wait
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_ext_req,
  input  wire logic i_cpu_gnt,
  input  wire logic i_ext_gnt,
  output logic      o_ext_priority
);

  generate
    if (MAX_WAIT == 0) begin : g_strict
      // EXT always wins contention, so no history is needed.
      logic w_unused_ok;
      assign w_unused_ok    = &{1'b0, clk, reset, i_ext_req, i_cpu_gnt, i_ext_gnt};
      assign o_ext_priority = 1'b1;
    end else begin : g_counted
      localparam int                 c_cnt_w = cnt_width(MAX_WAIT);
      localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_WAIT);
      localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

      logic [c_cnt_w-1:0] r_starve_cnt;

      // Saturating denial counter; any EXT grant or EXT going idle restarts it.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_starve_cnt <= '0;
        end else if (i_ext_gnt || !i_ext_req) begin
          r_starve_cnt <= '0;
        end else if (i_cpu_gnt && (r_starve_cnt != c_max)) begin
          r_starve_cnt <= r_starve_cnt + c_one;
        end
      end

      assign o_ext_priority = (r_starve_cnt >= c_max);
    end
  endgenerate

endmodule : dmem_starve_ctr
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares a single-port synchronous data memory between the CPU
//            load/store path and the EXT host port. CPU has fixed priority,
//            bounded by MAX_WAIT denials of EXT. Read data (1-cycle latency)
//            is steered back to whichever requester issued the read.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = c_addr_w,
  parameter int DATA_W   = c_data_w,
  parameter int MAX_WAIT = c_max_wait
) (
  input  wire logic     clk,
  input  wire logic     reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] c_addr_zero = '0;
  localparam logic [DATA_W-1:0] c_data_zero = '0;

  logic   w_ext_priority;
  logic   w_cpu_gnt;
  logic   w_ext_gnt;
  logic   r_own_vld;
  owner_e r_own_who;

  dmem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk            (clk),
    .reset          (reset),
    .i_ext_req      (bus.ext_req),
    .i_cpu_gnt      (w_cpu_gnt),
    .i_ext_gnt      (w_ext_gnt),
    .o_ext_priority (w_ext_priority)
  );

  // CPU wins unless EXT is contending and has hit its wait limit; no grants in reset.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ext_gnt = 1'b0;
    if (reset) begin
      if (bus.cpu_req && !(bus.ext_req && w_ext_priority)) begin
        w_cpu_gnt = 1'b1;
      end else if (bus.ext_req) begin
        w_ext_gnt = 1'b1;
      end
    end
  end

  // Steer the granted requester onto the memory port; drive zeros when idle.
  always_comb begin
    bus.mem_en    = w_cpu_gnt | w_ext_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = c_addr_zero;
    bus.mem_wdata = c_data_zero;
    if (w_cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (w_ext_gnt) begin
      bus.mem_we    = bus.ext_we;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end
  end

  // Remember who issued a granted read so next cycle's data goes to them;
  // reset discards any response still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_own_vld <= 1'b0;
      r_own_who <= OWN_CPU;
    end else begin
      r_own_vld <= (w_cpu_gnt && !bus.cpu_we) || (w_ext_gnt && !bus.ext_we);
      r_own_who <= w_ext_gnt ? OWN_EXT : OWN_CPU;
    end
  end

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.ext_gnt    = w_ext_gnt;
  assign bus.cpu_rvalid = r_own_vld && (r_own_who == OWN_CPU);
  assign bus.ext_rvalid = r_own_vld && (r_own_who == OWN_EXT);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ext_rdata  = bus.mem_rdata;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench: directed scenarios plus a randomized run
//            against a cycle-level reference model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MW = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus  ();
  dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) sbus ();

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(0)) u_strict (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous memory, one-cycle read latency.
  logic [15:0] tb_mem [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) tb_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= tb_mem[bus.mem_addr[7:0]];
    end
  end

  // Memory for the strict-priority instance returns an address-derived word.
  always @(posedge clk) begin
    if (sbus.mem_en && !sbus.mem_we) sbus.mem_rdata <= {8'hA5, sbus.mem_addr[7:0]};
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_cpu(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.cpu_req = r; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic drv_ext(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.ext_req = r; bus.ext_we = w; bus.ext_addr = a; bus.ext_wdata = d;
  endtask

  task automatic idle_cycle();
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drv_ext(1'b0, 1'b0, 16'h0, 16'h0);
    next();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    drv_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    drv_ext(1'b1, 1'b1, 16'h0020, 16'h1234);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (bus.cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_gnt: got %b expected 0", bus.cpu_gnt); end
      n_checks++; if (bus.ext_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_ext_gnt: got %b expected 0", bus.ext_gnt); end
      n_checks++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b expected 0", bus.mem_en); end
      n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
      n_checks++; if ({bus.cpu_rvalid, bus.ext_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 00", {bus.cpu_rvalid, bus.ext_rvalid}); end
    end
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drv_ext(1'b0, 1'b0, 16'h0, 16'h0);
    next();
    reset = 1'b1;
    idle_cycle();
  endtask

  task automatic test_uncontended();
    drv_cpu(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    @(negedge clk);
    n_checks++; if (bus.cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL unc_wr_gnt: got %b expected 1", bus.cpu_gnt); end
    n_checks++; if ({bus.mem_en, bus.mem_we} !== 2'b11) begin n_fail++; $display("FAIL unc_wr_en_we: got %b expected 11", {bus.mem_en, bus.mem_we}); end
    n_checks++; if ({bus.mem_addr, bus.mem_wdata} !== {16'h0010, 16'hBEEF}) begin n_fail++; $display("FAIL unc_wr_bus: got %h expected 0010beef", {bus.mem_addr, bus.mem_wdata}); end
    next();
    drv_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    n_checks++; if (bus.cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL unc_rd_gnt: got %b expected 1", bus.cpu_gnt); end
    n_checks++; if (bus.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL unc_wr_no_rvalid: got %b expected 0", bus.cpu_rvalid); end
    next();
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    n_checks++; if (bus.cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL unc_rvalid: got %b expected 1", bus.cpu_rvalid); end
    n_checks++; if (bus.cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL unc_rdata: got %h expected beef", bus.cpu_rdata); end
    n_checks++; if (bus.ext_rvalid !== 1'b0) begin n_fail++; $display("FAIL unc_ext_rvalid: got %b expected 0", bus.ext_rvalid); end
    n_checks++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL unc_idle_en: got %b expected 0", bus.mem_en); end
    idle_cycle();
  endtask

  task automatic test_fairness();
    bit prev_c;
    prev_c = 1'b0;
    drv_cpu(1'b1, 1'b0, 16'h0003, 16'h0);
    drv_ext(1'b1, 1'b0, 16'h0004, 16'h0);
    for (int i = 0; i < 15; i++) begin
      bit exp_c;
      exp_c = ((i % 5) != 4);
      @(negedge clk);
      n_checks++; if ({bus.cpu_gnt, bus.ext_gnt} !== {exp_c, !exp_c}) begin n_fail++; $display("FAIL fair_gnt[%0d]: got %b expected %b", i, {bus.cpu_gnt, bus.ext_gnt}, {exp_c, !exp_c}); end
      if (i > 0) begin
        n_checks++; if ({bus.cpu_rvalid, bus.ext_rvalid} !== {prev_c, !prev_c}) begin n_fail++; $display("FAIL fair_rvalid[%0d]: got %b expected %b", i, {bus.cpu_rvalid, bus.ext_rvalid}, {prev_c, !prev_c}); end
      end
      prev_c = exp_c;
      next();
    end
    idle_cycle();
  endtask

  task automatic test_interleaved();
    drv_ext(1'b1, 1'b1, 16'h0001, 16'h1111);
    next();
    drv_ext(1'b1, 1'b1, 16'h0002, 16'h2222);
    next();
    drv_ext(1'b0, 1'b0, 16'h0, 16'h0);
    drv_cpu(1'b1, 1'b0, 16'h0001, 16'h0);
    @(negedge clk);
    n_checks++; if (bus.cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL intl_cpu_gnt: got %b expected 1", bus.cpu_gnt); end
    next();
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drv_ext(1'b1, 1'b0, 16'h0002, 16'h0);
    @(negedge clk);
    n_checks++; if (bus.ext_gnt !== 1'b1) begin n_fail++; $display("FAIL intl_ext_gnt: got %b expected 1", bus.ext_gnt); end
    n_checks++; if ({bus.cpu_rvalid, bus.ext_rvalid} !== 2'b10) begin n_fail++; $display("FAIL intl_rv1: got %b expected 10", {bus.cpu_rvalid, bus.ext_rvalid}); end
    n_checks++; if (bus.cpu_rdata !== 16'h1111) begin n_fail++; $display("FAIL intl_cpu_rdata: got %h expected 1111", bus.cpu_rdata); end
    next();
    drv_ext(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    n_checks++; if ({bus.cpu_rvalid, bus.ext_rvalid} !== 2'b01) begin n_fail++; $display("FAIL intl_rv2: got %b expected 01", {bus.cpu_rvalid, bus.ext_rvalid}); end
    n_checks++; if (bus.ext_rdata !== 16'h2222) begin n_fail++; $display("FAIL intl_ext_rdata: got %h expected 2222", bus.ext_rdata); end
    idle_cycle();
  endtask

  task automatic test_drop_restart();
    drv_cpu(1'b1, 1'b0, 16'h0005, 16'h0);
    for (int i = 0; i < 8; i++) begin
      bit exp_e;
      exp_e = (i == 7);
      drv_ext((i != 2), 1'b0, 16'h0006, 16'h0);
      @(negedge clk);
      n_checks++; if ({bus.cpu_gnt, bus.ext_gnt} !== {!exp_e, exp_e}) begin n_fail++; $display("FAIL drop_gnt[%0d]: got %b expected %b", i, {bus.cpu_gnt, bus.ext_gnt}, {!exp_e, exp_e}); end
      next();
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    drv_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    n_checks++; if (bus.cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %b expected 1", bus.cpu_gnt); end
    next();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (bus.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid[%0d]: got %b expected 0", i, bus.cpu_rvalid); end
      n_checks++; if ({bus.cpu_gnt, bus.mem_en} !== 2'b00) begin n_fail++; $display("FAIL rmid_gnt_en[%0d]: got %b expected 00", i, {bus.cpu_gnt, bus.mem_en}); end
      next();
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_post_gnt: got %b expected 1", bus.cpu_gnt); end
    n_checks++; if (bus.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_post_stale: got %b expected 0", bus.cpu_rvalid); end
    next();
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    n_checks++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 16'hBEEF}) begin n_fail++; $display("FAIL rmid_post_rd: got %h expected 1beef", {bus.cpu_rvalid, bus.cpu_rdata}); end
    idle_cycle();
  endtask

  task automatic test_strict();
    sbus.cpu_req = 1'b1; sbus.cpu_we = 1'b0; sbus.cpu_addr = 16'h0005; sbus.cpu_wdata = 16'h0;
    sbus.ext_req = 1'b1; sbus.ext_we = 1'b0; sbus.ext_addr = 16'h0006; sbus.ext_wdata = 16'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if ({sbus.cpu_gnt, sbus.ext_gnt} !== 2'b01) begin n_fail++; $display("FAIL strict_gnt[%0d]: got %b expected 01", i, {sbus.cpu_gnt, sbus.ext_gnt}); end
      if (i > 0) begin
        n_checks++; if ({sbus.ext_rvalid, sbus.ext_rdata} !== {1'b1, 16'hA506}) begin n_fail++; $display("FAIL strict_ext_rd[%0d]: got %h expected 1a506", i, {sbus.ext_rvalid, sbus.ext_rdata}); end
      end
      next();
    end
    sbus.ext_req = 1'b0;
    @(negedge clk);
    n_checks++; if ({sbus.cpu_gnt, sbus.ext_gnt} !== 2'b10) begin n_fail++; $display("FAIL strict_cpu_alone: got %b expected 10", {sbus.cpu_gnt, sbus.ext_gnt}); end
    next();
    sbus.cpu_req = 1'b0;
    @(negedge clk);
    n_checks++; if ({sbus.cpu_rvalid, sbus.ext_rvalid, sbus.cpu_rdata} !== {2'b10, 16'hA505}) begin n_fail++; $display("FAIL strict_cpu_rd: got %h expected 2a505", {sbus.cpu_rvalid, sbus.ext_rvalid, sbus.cpu_rdata}); end
    next();
  endtask

  // Randomized traffic against a model: requests persist until granted,
  // EXT may be refused at most MW times in a row while contending.
  task automatic test_random();
    logic [15:0] ref_mem [int];
    int          waited;
    bit          pc, pe, ca, ea, cw, ew, exp_c, exp_e, denied;
    logic [15:0] pd, caddr, cdat, eaddr, edat;
    waited = 0; pc = 0; pe = 0; ca = 0; ea = 0; cw = 0; ew = 0;
    pd = 16'h0; caddr = 16'h0; cdat = 16'h0; eaddr = 16'h0; edat = 16'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!ca && ($urandom_range(0, 9) < 6)) begin
        ca = 1; cw = 1'($urandom_range(0, 1));
        caddr = 16'h0020 + 16'($urandom_range(0, 15)); cdat = 16'($urandom);
      end
      if (!ea && ($urandom_range(0, 9) < 5)) begin
        ea = 1; ew = 1'($urandom_range(0, 1));
        eaddr = 16'h0020 + 16'($urandom_range(0, 15)); edat = 16'($urandom);
      end
      drv_cpu(ca, cw, caddr, cdat);
      drv_ext(ea, ew, eaddr, edat);
      exp_c = ca && !(ea && (waited >= MW));
      exp_e = ea && !exp_c;
      @(negedge clk);
      n_checks++; if ({bus.cpu_gnt, bus.ext_gnt} !== {exp_c, exp_e}) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", cyc, {bus.cpu_gnt, bus.ext_gnt}, {exp_c, exp_e}); end
      n_checks++; if (bus.mem_en !== (exp_c || exp_e)) begin n_fail++; $display("FAIL rnd_mem_en[%0d]: got %b expected %b", cyc, bus.mem_en, exp_c || exp_e); end
      if (exp_c || exp_e) begin
        n_checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== (exp_c ? {cw, caddr, cdat} : {ew, eaddr, edat})) begin
          n_fail++; $display("FAIL rnd_mem_bus[%0d]: got %h expected %h", cyc, {bus.mem_we, bus.mem_addr, bus.mem_wdata}, (exp_c ? {cw, caddr, cdat} : {ew, eaddr, edat}));
        end
      end
      n_checks++; if ({bus.cpu_rvalid, bus.ext_rvalid} !== {pc, pe}) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", cyc, {bus.cpu_rvalid, bus.ext_rvalid}, {pc, pe}); end
      if (pc || pe) begin
        n_checks++; if ((pc ? bus.cpu_rdata : bus.ext_rdata) !== pd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", cyc, (pc ? bus.cpu_rdata : bus.ext_rdata), pd); end
      end
      denied = ea && !exp_e;
      pc = exp_c && !cw;
      pe = exp_e && !ew;
      if (exp_c) begin
        if (cw) ref_mem[int'(caddr)] = cdat;
        else    pd = ref_mem.exists(int'(caddr)) ? ref_mem[int'(caddr)] : 16'h0;
        ca = 0;
      end
      if (exp_e) begin
        if (ew) ref_mem[int'(eaddr)] = edat;
        else    pd = ref_mem.exists(int'(eaddr)) ? ref_mem[int'(eaddr)] : 16'h0;
        ea = 0;
      end
      waited = denied ? ((waited < MW) ? waited + 1 : MW) : 0;
      next();
    end
    idle_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 16'h0;
    bus.mem_rdata  = 16'h0;
    sbus.mem_rdata = 16'h0;
    sbus.cpu_req = 1'b0; sbus.cpu_we = 1'b0; sbus.cpu_addr = 16'h0; sbus.cpu_wdata = 16'h0;
    sbus.ext_req = 1'b0; sbus.ext_we = 1'b0; sbus.ext_addr = 16'h0; sbus.ext_wdata = 16'h0;
    drv_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drv_ext(1'b0, 1'b0, 16'h0, 16'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_uncontended();
    test_fairness();
    test_interleaved();
    test_drop_restart();
    test_reset_mid();
    test_strict();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters:
  - the processor's stage-2 load/store path (CPU);
  - an external host/loader port (EXT), used for program data preload and debug readback.
- Fixed CPU priority with a bounded-starvation guarantee for EXT.
- Synchronous memory with 1-cycle read latency; the read response is routed back to the requester that issued it.
- Sits between the processor core and the data memory array.

Parameters:
- ADDR_W, 16, address width (matches the processor address size).
- DATA_W, 16, data width (matches the processor data word).
- MAX_WAIT, 4, max consecutive cycles EXT may be denied while CPU is granted; 0 = EXT has strict priority.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  EXT request, same meaning as the CPU fields.
- ext_gnt  out  1  EXT request accepted this cycle.
- ext_rvalid  out  1  EXT read data valid.
- ext_rdata  out  DATA_W  EXT read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0.

Behaviour:
- Handshake:
  - A requester holds req and all request fields stable until it samples gnt=1 at a posedge.
  - The transfer occurs on that edge.
  - req may drop the cycle after a grant or stay high for back-to-back accesses.
- Grant logic is combinational from req inputs and starve_cnt. At most one gnt per cycle. No gnt without the matching req.
- Arbitration:
  - Only one requesting: that one is granted.
  - Both requesting: CPU granted if starve_cnt < MAX_WAIT, otherwise EXT granted.
- starve_cnt (width clog2(MAX_WAIT+1), min 1):
  - increments when ext_req && cpu_gnt, saturating at MAX_WAIT;
  - clears to 0 when ext_gnt, or when ext_req=0.
- Memory drive:
  - mem_en = cpu_gnt | ext_gnt.
  - mem_we/addr/wdata muxed from the granted requester.
  - When idle: mem_en=0, mem_we=0, other fields don't-care (drive 0).
- Read response:
  - A granted read sets owner register {valid, who} at the edge.
  - Next cycle: the matching xxx_rvalid=1 and xxx_rdata=mem_rdata; the other rvalid stays 0.
  - Writes never produce rvalid.
  - Back-to-back reads give rvalid on consecutive cycles.
  - rdata outputs are don't-care when rvalid=0; implement as a mem_rdata pass-through.
- Latency: grant is 0 cycles when uncontended; read data arrives 1 cycle after grant.
- Simultaneous events: a grant in cycle N and a response to the grant from cycle N-1 coexist with no conflict.
- Reset (reset=0, async):
  - starve_cnt=0, owner valid=0.
  - cpu_gnt=ext_gnt=0, mem_en=0, mem_we=0, cpu_rvalid=ext_rvalid=0 while reset is low (gnts gated by reset).
  - A read granted the cycle before reset asserts has its rvalid dropped, not delivered after release.
- MAX_WAIT=0: EXT always wins contention; CPU is granted only when EXT is idle.

Decomposition:
- Shared package (or define file): ADDR/DATA widths (16), owner encoding OWN_CPU=0 / OWN_EXT=1, default MAX_WAIT.
- One natural sub-module: dmem_starve_ctr. It holds the saturating counter plus the compare, and outputs ext_priority = (starve_cnt >= MAX_WAIT).
- Top level holds the grant mux, memory mux and response owner register.

Test Plan:
- Uncontended CPU write addr 0x0010 data 0xBEEF, then CPU read 0x0010 -> cpu_gnt same cycle each time; cpu_rvalid=1 with cpu_rdata=0xBEEF one cycle after the read grant; ext_rvalid stays 0.
- CPU and EXT both requesting continuously, MAX_WAIT=4 -> grant pattern C,C,C,C,E repeating; EXT never waits more than 4 cycles.
- Interleaved reads: CPU reads 0x0001 (=0x1111) in cycle N, EXT reads 0x0002 (=0x2222) in cycle N+1 -> cpu_rvalid/0x1111 at N+1, ext_rvalid/0x2222 at N+2, never both rvalids high.
- EXT drops req after 2 denied cycles, reasserts later -> starve_cnt restarts from 0; EXT gets a grant only after 4 further denials.
- Assert reset low in the cycle after a CPU read grant -> cpu_rvalid stays 0; all gnt/mem_en low during reset; first access after release behaves as uncontended.
- MAX_WAIT=0 build, both requesting -> ext_gnt every cycle; cpu_gnt=0 until ext_req drops.
